aes_enc_sched: RTL and testbench

AES_ENC_SCHED -- requirements
Module: aes_enc_sched

---
 rtl/aes_enc_sched.sv | 135 +++++++++++++
 tb/tb_aes_enc_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_sched.sv
// rtl/aes_enc_sched.sv - key/plaintext scheduler for a pipelined AES core with credit-limited output FIFO
// Optional AES_SCHED_STATS_EN adds the blk_count output-handshake counter.
module aes_enc_sched #(
  parameter int PIPE_LAT   = 10,
  parameter int KEY_LAT    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [127:0] core_key,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  // The core_data_in stage is in flight too, so up to PIPE_LAT+1 blocks can be outstanding.
  localparam int OW = $clog2(PIPE_LAT + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int KW = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;
  localparam logic [31:0] DEPTH_U = FIFO_DEPTH;

  typedef enum logic [1:0] {NOKEY, DRAIN, KEYWAIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [KW-1:0]       kcnt;
  logic [127:0]        pend_key;
  logic                acc_q;
  logic [PIPE_LAT-1:0] vld;
  logic [OW-1:0]       outstanding;
  logic [127:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [CW-1:0]       fifo_count;
  logic [31:0]         used;
  logic                accept, push, pop, kwait_done, enter_kwait;

  assign used        = 32'(outstanding) + 32'(fifo_count);
  assign key_busy    = (state != RUN);
  assign in_ready    = (state == RUN) && !key_load && (used < DEPTH_U);
  assign accept      = in_valid && in_ready;
  assign push        = vld[PIPE_LAT-1];
  assign out_valid   = (fifo_count != '0);
  assign out_data    = mem[rptr];
  assign pop         = out_valid && out_ready;
  assign kwait_done  = (kcnt == KW'(KEY_LAT - 1));
  assign enter_kwait = (state != KEYWAIT) && (state_nxt == KEYWAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      NOKEY:   if (key_load) state_nxt = KEYWAIT;
      RUN:     if (key_load) state_nxt = DRAIN;
      DRAIN:   if (outstanding == '0) state_nxt = KEYWAIT;
      KEYWAIT: if (kwait_done) state_nxt = RUN;
      default: state_nxt = NOKEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= NOKEY;
    else     state <= state_nxt;
  end

  // A key requested in RUN waits in pend_key until the pipeline has drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_key <= '0;
      pend_key <= '0;
      kcnt     <= '0;
    end else begin
      if (state == RUN && key_load) pend_key <= key_in;
      if (enter_kwait) core_key <= (state == NOKEY) ? key_in : pend_key;
      if (state == KEYWAIT) kcnt <= kcnt + KW'(1);
      else                  kcnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      core_data_in <= '0;
      acc_q        <= 1'b0;
      vld          <= '0;
      outstanding  <= '0;
    end else begin
      if (accept) core_data_in <= in_data;
      acc_q <= accept;
      vld   <= PIPE_LAT'({vld, acc_q});
      case ({accept, push})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= core_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef AES_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)      blk_count <= '0;
    else if (pop) blk_count <= blk_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_aes_enc_sched.sv
// tb/tb_aes_enc_sched.sv - directed self-checking bench for aes_enc_sched
// Uses a stand-in cipher pipeline; AES_SCHED_STATS_EN enables blk_count checks.
module tb_aes_enc_sched;
  localparam int PIPE_LAT   = 10;
  localparam int KEY_LAT    = 10;
  localparam int FIFO_DEPTH = 16;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_busy;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] core_key;
  logic [127:0] core_data_in;
  logic [127:0] core_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef AES_SCHED_STATS_EN
  logic [31:0]  blk_count;
`endif

  aes_enc_sched #(.PIPE_LAT(PIPE_LAT), .KEY_LAT(KEY_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load), .key_busy(key_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_key(core_key), .core_data_in(core_data_in), .core_data_out(core_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef AES_SCHED_STATS_EN
    , .blk_count(blk_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           n_acc = 0;
  int           n_out = 0;
  int           n_hs  = 0;
  int           stall;
  int           guard;
  logic [127:0] cur_key;
  logic [127:0] exp_q[$];
  logic [127:0] pipe [PIPE_LAT];

  // Stand-in cipher: the FIPS-197 example pair, otherwise data XOR key.
  function automatic logic [127:0] cipher(input logic [127:0] d, input logic [127:0] k);
    return (d == PT && k == K1) ? CT : (d ^ k);
  endfunction

  always @(posedge clk) begin
    pipe[0] <= cipher(core_data_in, core_key);
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign core_data_out = pipe[PIPE_LAT-1];

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes due at the coming edge, then move to the next falling edge.
  task automatic cyc();
    logic acc;
    #1;
    acc = in_valid && in_ready;
    if (acc) begin
      exp_q.push_back(cipher(in_data, cur_key));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      n_hs++;
      if (exp_q.size() == 0) chk_int("out_extra", exp_q.size(), 1);
      else begin
        chk_word("out_data", out_data, exp_q.pop_front());
        n_out++;
      end
    end
    @(negedge clk);
    if (acc) in_data = in_data + 128'd1;
  endtask

  initial begin
    rst = 1'b1; key_in = '0; key_load = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; cur_key = '0;
    @(negedge clk);
    in_valid = 1'b1;
    cyc();
    chk_bit("rst_key_busy", key_busy, 1'b1);
    chk_bit("rst_in_ready", in_ready, 1'b0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_word("rst_core_key", core_key, '0);
    chk_word("rst_core_data_in", core_data_in, '0);
    rst = 1'b0; in_valid = 1'b0;

    // Key load: busy for the load cycle plus KEY_LAT cycles
    key_in = K1; key_load = 1'b1; cur_key = K1;
    chk_bit("load_busy", key_busy, 1'b1);
    cyc();
    key_load = 1'b0;
    for (int i = 0; i < KEY_LAT; i++) begin
      chk_bit("keywait_busy", key_busy, 1'b1);
      chk_bit("keywait_in_ready", in_ready, 1'b0);
      cyc();
    end
    chk_bit("run_busy", key_busy, 1'b0);
    chk_bit("run_in_ready", in_ready, 1'b1);
    chk_word("core_key_k1", core_key, K1);

    // Single block: out_valid appears PIPE_LAT+1 edges after accept
    in_data = PT; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk_word("core_data_in_pt", core_data_in, PT);
    for (int i = 0; i <= PIPE_LAT; i++) begin
      chk_bit("single_latency_low", out_valid, 1'b0);
      cyc();
    end
    chk_bit("single_out_valid", out_valid, 1'b1);
    chk_word("single_ciphertext", out_data, CT);
    out_ready = 1'b1;
    cyc();
    chk_bit("single_popped", out_valid, 1'b0);

    // Backpressure: 40 blocks offered, credits stop at FIFO_DEPTH
    out_ready = 1'b0; in_data = 128'hA5A5_0000_0000_0000_0000_0000_0000_1000;
    in_valid = 1'b1; n_acc = 0; n_out = 0;
    for (int i = 0; i < 40; i++) cyc();
    chk_int("bp_accepts", n_acc, FIFO_DEPTH);
    chk_bit("bp_in_ready", in_ready, 1'b0);
    chk_bit("bp_out_valid", out_valid, 1'b1);
    chk_word("bp_stall_data", out_data, exp_q[0]);
    cyc();
    chk_word("bp_hold_data", out_data, exp_q[0]);
    out_ready = 1'b1; guard = 0;
    while (n_out < 40 && guard < 400) begin
      if (n_acc == 40) in_valid = 1'b0;
      cyc();
      guard++;
    end
    in_valid = 1'b0;
    chk_int("bp_out_count", n_out, 40);
    chk_int("bp_queue_empty", exp_q.size(), 0);
`ifdef AES_SCHED_STATS_EN
    chk_int("blk_count_hs", int'(blk_count), n_hs);
`endif

    // Key change with 5 blocks in flight
    in_data = 128'h5555_0000_0000_0000_0000_0000_0000_2000; in_valid = 1'b1;
    n_acc = 0; n_out = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk_int("kc_old_accepts", n_acc, 5);
    key_in = K2; key_load = 1'b1;
    #1;
    chk_bit("kc_ready_on_load", in_ready, 1'b0);
    cyc();
    key_load = 1'b0; cur_key = K2; stall = 1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (in_ready) break;
      stall++;
      cyc();
    end
    chk_int("kc_stall_cycles", stall, 1 + (PIPE_LAT + 1) + KEY_LAT);
    chk_int("kc_old_outputs", n_out, 5);
    chk_word("core_key_k2", core_key, K2);
    for (int i = 0; i < 4; i++) cyc();
    in_valid = 1'b0; guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      cyc();
      guard++;
    end
    chk_int("kc_new_outputs", n_out, 9);

    // Reset with 8 in flight and 3 buffered
    out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
    for (int i = 0; i < 11; i++) cyc();
    in_valid = 1'b0;
    chk_int("rm_accepts", n_acc, 11);
    for (int i = 0; i < 3; i++) cyc();
    chk_bit("rm_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; exp_q.delete(); out_ready = 1'b1; in_valid = 1'b1;
`ifdef AES_SCHED_STATS_EN
    chk_int("blk_count_rst", int'(blk_count), 0);
`endif
    for (int i = 0; i < 30; i++) begin
      chk_bit("rm_out_valid", out_valid, 1'b0);
      chk_bit("rm_key_busy", key_busy, 1'b1);
      chk_bit("rm_in_ready", in_ready, 1'b0);
      cyc();
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
